// File: rtl/memory_fifo_ctrl.sv
// FIFO controller driving an external 2^ADDR_WIDTH-word RAM tile with registered read.
// A 2-entry output skid buffer hides the RAM read latency so both streams run at 1 word/cycle.
module memory_fifo_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_mem_count;
  logic                  r_rd_pend;
  logic [DATA_WIDTH-1:0] r_obuf [2];
  logic                  r_obuf_head;
  logic [1:0]            r_obuf_cnt;

  logic                  w_s_ready;
  logic                  w_push;
  logic                  w_m_valid;
  logic                  w_pop;
  logic                  w_credit_ok;
  logic                  w_issue;
  logic                  w_obuf_tail;

  assign w_s_ready = (r_mem_count != FULL_COUNT) && !flush;
  // Write enable is held low while reset is asserted even though s_ready idles high.
  assign w_push    = s_valid && w_s_ready && rst_n;
  assign w_m_valid = (r_obuf_cnt != 2'd0);
  assign w_pop     = w_m_valid && m_ready && !flush;

  // A read may only be issued if the skid buffer will have a free slot when its data lands.
  assign w_credit_ok = (({1'b0, r_obuf_cnt} + {2'b00, r_rd_pend}) < (3'd2 + {2'b00, w_pop}));
  assign w_issue     = (r_mem_count != '0) && w_credit_ok && !flush;

  // A capture only happens with at most one entry held, so tail is head or head+1.
  assign w_obuf_tail = r_obuf_head ^ r_obuf_cnt[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_count <= '0;
      r_rd_pend   <= 1'b0;
      r_obuf[0]   <= '0;
      r_obuf[1]   <= '0;
      r_obuf_head <= 1'b0;
      r_obuf_cnt  <= 2'd0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_count <= '0;
      r_rd_pend   <= 1'b0;
      r_obuf[0]   <= '0;
      r_obuf[1]   <= '0;
      r_obuf_head <= 1'b0;
      r_obuf_cnt  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_mem_count <= r_mem_count + {{ADDR_WIDTH{1'b0}}, w_push}
                                 - {{ADDR_WIDTH{1'b0}}, w_issue};
      r_rd_pend   <= w_issue;
      if (r_rd_pend) r_obuf[w_obuf_tail] <= mem_data_out;
      if (w_pop) r_obuf_head <= ~r_obuf_head;
      r_obuf_cnt  <= r_obuf_cnt + {1'b0, r_rd_pend} - {1'b0, w_pop};
    end
  end

  assign s_ready     = w_s_ready;
  assign mem_wen     = w_push;
  assign mem_waddr   = r_wr_ptr;
  assign mem_data_in = s_data;
  assign mem_ren     = w_issue;
  assign mem_raddr   = r_rd_ptr;
  assign m_valid     = w_m_valid;
  assign m_data      = r_obuf[r_obuf_head];
  assign level       = r_mem_count + (ADDR_WIDTH+1)'(r_rd_pend) + (ADDR_WIDTH+1)'(r_obuf_cnt);
  assign empty       = (level == '0);

endmodule
